// File: rtl/fft_output_serializer_if.sv
// fft_output_serializer_if: parallel FFT vector in, one complex sample per beat out.
// recv side : recv_msg_real/imag (N_SAMPLES x BIT_WIDTH), recv_val, recv_rdy
// send side : send_msg_real/imag (BIT_WIDTH), send_idx, send_last, send_val, send_rdy
// slave modport is the serializer view; master modport is the producer/consumer view.
interface fft_output_serializer_if #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
);
   localparam int IW = $clog2(N_SAMPLES);
   logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_real;
   logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_imag;
   logic                                recv_val;
   logic                                recv_rdy;
   logic [BIT_WIDTH-1:0]                send_msg_real;
   logic [BIT_WIDTH-1:0]                send_msg_imag;
   logic [IW-1:0]                       send_idx;
   logic                                send_last;
   logic                                send_val;
   logic                                send_rdy;
   modport slave (
      input  recv_msg_real, recv_msg_imag, recv_val, send_rdy,
      output recv_rdy, send_msg_real, send_msg_imag, send_idx, send_last, send_val
   );
   modport master (
      output recv_msg_real, recv_msg_imag, recv_val, send_rdy,
      input  recv_rdy, send_msg_real, send_msg_imag, send_idx, send_last, send_val
   );
endinterface

// File: rtl/fft_output_serializer.sv
// fft_output_serializer: captures an N-sample complex vector and streams it one sample per beat.
// clk   : rising-edge clock
// reset : synchronous, active-low
// io    : slave view of fft_output_serializer_if (recv vector handshake, send sample handshake)
module fft_output_serializer #(
   parameter int BIT_WIDTH   = 32,
   parameter int N_SAMPLES   = 8,
   parameter int BIT_REVERSE = 0
) (
   input logic                 clk,
   input logic                 reset,
   fft_output_serializer_if.slave io
);
   localparam int W = $clog2(N_SAMPLES);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;
   logic [W-1:0] cnt, cnt_nxt, rev, sel;
   logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] buf_real, buf_imag;
   logic at_last, in_fire, out_fire;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         buf_real <= '0;
         buf_imag <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (in_fire) begin
            buf_real <= io.recv_msg_real;
            buf_imag <= io.recv_msg_imag;
         end
      end
   end
   always_comb begin
      rev = '0;
      for (int i = 0; i < W; i++) rev[i] = cnt[W-1-i];
      sel      = (BIT_REVERSE != 0) ? rev : cnt;
      at_last  = (state == SEND) && (cnt == W'(N_SAMPLES-1));
      // Accepting on the last-beat fire keeps back-to-back vectors bubble-free.
      io.recv_rdy = reset && ((state == IDLE) || (at_last && io.send_rdy));
      io.send_val = reset && (state == SEND);
      in_fire  = io.recv_val && io.recv_rdy;
      out_fire = io.send_val && io.send_rdy;
      state_nxt = in_fire ? SEND : (out_fire && at_last) ? IDLE : state;
      cnt_nxt   = (in_fire || (out_fire && at_last)) ? '0 : out_fire ? cnt + W'(1) : cnt;
      io.send_msg_real = buf_real[sel];
      io.send_msg_imag = buf_imag[sel];
      io.send_idx      = sel;
      io.send_last     = at_last;
   end
endmodule

// File: tb/tb_fft_output_serializer.sv
// tb_fft_output_serializer: directed checks of the serializer in index and bit-reversed order.
// Two DUTs (BIT_REVERSE=0 and 1) share clk, reset and all stimulus.
module tb_fft_output_serializer;
   logic clk = 1'b0;
   logic reset;
   logic recv_val, send_rdy;
   logic [7:0][31:0] real_v, imag_v;
   int checks = 0;
   int errors = 0;
   typedef struct {
      int idx0;
      int real0;
      int idx1;
      int real1;
      logic last;
   } beat_t;
   beat_t tbl [8];
   always #5 clk = ~clk;
   fft_output_serializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) io0 ();
   fft_output_serializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) io1 ();
   assign io0.recv_msg_real = real_v;
   assign io0.recv_msg_imag = imag_v;
   assign io0.recv_val      = recv_val;
   assign io0.send_rdy      = send_rdy;
   assign io1.recv_msg_real = real_v;
   assign io1.recv_msg_imag = imag_v;
   assign io1.recv_val      = recv_val;
   assign io1.send_rdy      = send_rdy;
   fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .BIT_REVERSE(0)) dut0 (
      .clk(clk), .reset(reset), .io(io0.slave));
   fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .BIT_REVERSE(1)) dut1 (
      .clk(clk), .reset(reset), .io(io1.slave));
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic load_vec(input int base);
      for (int i = 0; i < 8; i++) begin
         real_v[i] = 32'(base + i + 1);
         imag_v[i] = 32'(-(base + i + 1));
      end
   endtask
   task automatic scramble(input int k);
      for (int i = 0; i < 8; i++) begin
         real_v[i] = 32'hdead0000 + 32'(k * 16 + i);
         imag_v[i] = 32'hbeef0000 + 32'(k * 16 + i);
      end
   endtask
   task automatic chk_beat(input string tag, input int base, input int k);
      chk({tag, " val0"},  {31'd0, io0.send_val}, 32'd1);
      chk({tag, " val1"},  {31'd0, io1.send_val}, 32'd1);
      chk({tag, " idx0"},  {29'd0, io0.send_idx}, 32'(tbl[k].idx0));
      chk({tag, " real0"}, io0.send_msg_real, 32'(base + tbl[k].real0));
      chk({tag, " imag0"}, io0.send_msg_imag, 32'(-(base + tbl[k].real0)));
      chk({tag, " idx1"},  {29'd0, io1.send_idx}, 32'(tbl[k].idx1));
      chk({tag, " real1"}, io1.send_msg_real, 32'(base + tbl[k].real1));
      chk({tag, " last0"}, {31'd0, io0.send_last}, {31'd0, tbl[k].last});
      chk({tag, " last1"}, {31'd0, io1.send_last}, {31'd0, tbl[k].last});
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, " val0"}, {31'd0, io0.send_val}, 32'd0);
      chk({tag, " val1"}, {31'd0, io1.send_val}, 32'd0);
   endtask
   initial begin
      tbl[0] = '{0, 1, 0, 1, 1'b0};
      tbl[1] = '{1, 2, 4, 5, 1'b0};
      tbl[2] = '{2, 3, 2, 3, 1'b0};
      tbl[3] = '{3, 4, 6, 7, 1'b0};
      tbl[4] = '{4, 5, 1, 2, 1'b0};
      tbl[5] = '{5, 6, 5, 6, 1'b0};
      tbl[6] = '{6, 7, 3, 4, 1'b0};
      tbl[7] = '{7, 8, 7, 8, 1'b1};
      reset = 1'b0;
      recv_val = 1'b1;
      send_rdy = 1'b1;
      load_vec(0);
      tick();
      tick();
      #2;
      chk("reset recv_rdy", {31'd0, io0.recv_rdy}, 32'd0);
      chk_idle("reset");
      recv_val = 1'b0;
      reset = 1'b1;
      tick();
      #2;
      chk("idle recv_rdy", {31'd0, io0.recv_rdy}, 32'd1);
      chk_idle("idle");
      // single vector, inputs scrambled every cycle after the fire
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      for (int k = 0; k < 8; k++) begin
         scramble(k);
         #2;
         chk_beat("single", 0, k);
         chk("single recv_rdy", {31'd0, io0.recv_rdy}, (k == 7) ? 32'd1 : 32'd0);
         tick();
      end
      #2;
      chk_idle("single end");
      chk("single end recv_rdy", {31'd0, io1.recv_rdy}, 32'd1);
      // backpressure with send_rdy pattern 1,0,0,1,...
      load_vec(100);
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      begin
         int b = 0;
         int c = 0;
         while (b < 8 && c < 40) begin
            send_rdy = (c % 3) == 0;
            #2;
            chk_beat("bp", 100, b);
            chk("bp recv_rdy", {31'd0, io0.recv_rdy}, (b == 7 && send_rdy) ? 32'd1 : 32'd0);
            if (send_rdy) b++;
            c++;
            tick();
         end
         chk("bp beats drained", 32'(b), 32'd8);
      end
      send_rdy = 1'b1;
      #2;
      chk_idle("bp end");
      // back-to-back vectors A then B with no idle cycle
      load_vec(200);
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            load_vec(300);
            recv_val = 1'b1;
         end
         #2;
         chk_beat("b2b A", 200, k);
         chk("b2b A recv_rdy", {31'd0, io0.recv_rdy}, (k == 7) ? 32'd1 : 32'd0);
         tick();
      end
      recv_val = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #2;
         chk_beat("b2b B", 300, k);
         tick();
      end
      #2;
      chk_idle("b2b end");
      // reset after three beats drops the rest of the vector
      load_vec(400);
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk_beat("mid", 400, k);
         tick();
      end
      reset = 1'b0;
      #2;
      chk_idle("mid reset low");
      tick();
      reset = 1'b1;
      #2;
      chk_idle("mid after reset");
      chk("mid recv_rdy", {31'd0, io0.recv_rdy}, 32'd1);
      load_vec(500);
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #2;
         chk_beat("restart", 500, k);
         tick();
      end
      #2;
      chk_idle("restart end");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
